// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : Four-requester round-robin arbiter with a bounded hold time.
//            A registered 2-bit grant index is decoded into a one-hot grant
//            vector, qualified by a valid flag. A hold counter limits each
//            tenure to MAX_HOLD cycles while other requesters are waiting.
// Ports    : clk       - clock, all state changes on the rising edge
//            rst       - synchronous active-high reset
//            req[3:0]  - request vector, req[i] held high until done
//            gnt[3:0]  - one-hot grant (all zero when no grant is active)
//            gnt_idx   - index of the current or most recent grantee
//            gnt_valid - high while a grant is active
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8   // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_grant = 1'b1;
  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

  logic [0:0] state_q,    state_d;
  logic [1:0] gnt_idx_q,  gnt_idx_d;
  logic [1:0] last_idx_q, last_idx_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [1:0] w_base;
  logic [2:0] w_pick;     // {found, index}
  logic       w_cur_req;
  logic       w_others;

  function automatic logic [3:0] decode2(input logic [1:0] idx);
    decode2 = 4'b0001 << idx;
  endfunction

  // Search order base+1, base+2, base+3, base+4 (mod 4). Iterating from the
  // farthest offset down lets the nearest set bit overwrite the result.
  function automatic logic [2:0] rr_pick(input logic [1:0] base,
                                         input logic [3:0] mask);
    logic [1:0] cand;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand = base + 2'(k);
      if (mask[cand]) rr_pick = {1'b1, cand};
    end
  endfunction

  // In GRANT the current holder sits at offset 4, so it only wins the shared
  // search when nobody else asks, which the release/preempt paths never use.
  assign w_base    = (state_q == c_st_idle) ? last_idx_q : gnt_idx_q;
  assign w_pick    = rr_pick(w_base, req);
  assign w_cur_req = req[gnt_idx_q];
  assign w_others  = |(req & ~decode2(gnt_idx_q));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_idle;
      gnt_idx_q  <= 2'b00;
      last_idx_q <= 2'b11;   // first grant after reset favours requester 0
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      c_st_idle: begin
        if (w_pick[2]) begin
          state_d    = c_st_grant;
          gnt_idx_d  = w_pick[1:0];
          hold_cnt_d = 8'd0;
        end
      end
      c_st_grant: begin
        if (!w_cur_req) begin
          // Holder released: hand off with no gap, or fall back to idle.
          last_idx_d = gnt_idx_q;
          hold_cnt_d = 8'd0;
          if (w_pick[2]) begin
            gnt_idx_d = w_pick[1:0];
          end else begin
            state_d = c_st_idle;
          end
        end else if (hold_cnt_q == c_hold_last) begin
          // Tenure limit: preempt only if someone else is waiting.
          hold_cnt_d = 8'd0;
          if (w_others) begin
            last_idx_d = gnt_idx_q;
            gnt_idx_d  = w_pick[1:0];
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Output logic: decoded from registers only, no path from req.
  always_comb begin
    gnt_valid = (state_q == c_st_grant);
    gnt_idx   = gnt_idx_q;
    gnt       = gnt_valid ? decode2(gnt_idx_q) : 4'b0000;
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4
// Purpose  : Self-checking bench for rr_arbiter4. Instance u_dut8 uses
//            MAX_HOLD=8, u_dut1 uses MAX_HOLD=1. Directed vector table,
//            hand-written multi-cycle sequences, then randomized traffic
//            checked against a behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req8, req1;
  logic [3:0] gnt8, gnt1;
  logic [1:0] idx8, idx1;
  logic       val8, val1;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8)) u_dut8 (
    .clk(clk), .rst(rst), .req(req8),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(val8)
  );

  rr_arbiter4 #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(val1)
  );

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] idx;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] g,
                              logic v, logic [1:0] i);
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g; t.valid = v; t.idx = i;
    return t;
  endfunction

  task automatic chk(input string name, input logic [6:0] act,
                     input logic [6:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {gnt,valid,idx}=%b expected %b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // ten = number of cycles the current holder has seen gnt high.
  int m_max[2]  = '{8, 1};
  bit m_busy[2];
  int m_cur[2];
  int m_last[2];
  int m_ten[2];

  function automatic int rr(int base, logic [3:0] q);
    for (int k = 1; k <= 4; k++)
      if (q[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  task automatic model_step(input int u, input logic r, input logic [3:0] q);
    logic [3:0] others;
    if (r) begin
      m_busy[u] = 0; m_cur[u] = 0; m_last[u] = 3; m_ten[u] = 0;
    end else if (!m_busy[u]) begin
      if (q != 4'b0) begin
        m_cur[u] = rr(m_last[u], q); m_busy[u] = 1; m_ten[u] = 1;
      end
    end else begin
      others = q & ~(4'b0001 << m_cur[u]);
      if (!q[m_cur[u]]) begin
        m_last[u] = m_cur[u];
        if (others != 4'b0) begin
          m_cur[u] = rr(m_cur[u], q); m_ten[u] = 1;
        end else begin
          m_busy[u] = 0;
        end
      end else if (m_ten[u] == m_max[u]) begin
        if (others != 4'b0) begin
          m_last[u] = m_cur[u]; m_cur[u] = rr(m_cur[u], q);
        end
        m_ten[u] = 1;
      end else begin
        m_ten[u]++;
      end
    end
  endtask

  function automatic logic [6:0] model_out(int u);
    logic [3:0] g;
    g = m_busy[u] ? (4'b0001 << m_cur[u]) : 4'b0000;
    return {g, m_busy[u], 2'(m_cur[u])};
  endfunction

  initial begin
    // ---------- directed vector table (MAX_HOLD=8 instance) ----------
    vecs[0]  = mk(1, 4'b1111, 4'b0000, 0, 2'd0);  // in reset
    vecs[1]  = mk(1, 4'b1111, 4'b0000, 0, 2'd0);
    vecs[2]  = mk(0, 4'b1111, 4'b0001, 1, 2'd0);  // first grant -> 0
    vecs[3]  = mk(0, 4'b0000, 4'b0000, 0, 2'd0);  // release to idle
    vecs[4]  = mk(0, 4'b0100, 4'b0100, 1, 2'd2);  // single requester x5
    vecs[5]  = mk(0, 4'b0100, 4'b0100, 1, 2'd2);
    vecs[6]  = mk(0, 4'b0100, 4'b0100, 1, 2'd2);
    vecs[7]  = mk(0, 4'b0100, 4'b0100, 1, 2'd2);
    vecs[8]  = mk(0, 4'b0100, 4'b0100, 1, 2'd2);
    vecs[9]  = mk(0, 4'b0000, 4'b0000, 0, 2'd2);  // drop one cycle later
    vecs[10] = mk(0, 4'b0010, 4'b0010, 1, 2'd1);  // grant idx 1
    vecs[11] = mk(0, 4'b0011, 4'b0010, 1, 2'd1);
    vecs[12] = mk(0, 4'b1001, 4'b1000, 1, 2'd3);  // base 1: 2,3,0 -> 3
    vecs[13] = mk(0, 4'b1001, 4'b1000, 1, 2'd3);
    vecs[14] = mk(0, 4'b0000, 4'b0000, 0, 2'd3);
    vecs[15] = mk(0, 4'b0100, 4'b0100, 1, 2'd2);  // base 3 -> 2
    vecs[16] = mk(1, 4'b0100, 4'b0000, 0, 2'd0);  // reset mid-grant
    vecs[17] = mk(0, 4'b1111, 4'b0001, 1, 2'd0);  // first grant -> 0
    vecs[18] = mk(0, 4'b0000, 4'b0000, 0, 2'd0);

    req1 = 4'b0000;
    for (int i = 0; i < 19; i++) begin
      rst  = vecs[i].rst;
      req8 = vecs[i].req;
      step();
      chk($sformatf("vec%0d", i), {gnt8, val8, idx8},
          {vecs[i].gnt, vecs[i].valid, vecs[i].idx});
    end

    // ---------- single requester beyond MAX_HOLD: keeps grant ----------
    req8 = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("hold20_%0d", k), {gnt8, val8, idx8}, {4'b0100, 1'b1, 2'd2});
    end

    // ---------- preemption, MAX_HOLD=8, req=0011 ----------
    rst = 1'b1; req8 = 4'b0011;
    step();
    chk("preempt_rst", {gnt8, val8, idx8}, 7'b0);
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      logic [1:0] ei;
      step();
      ei = 2'((k / 8) % 2);
      chk($sformatf("preempt_%0d", k), {gnt8, val8, idx8},
          {4'b0001 << ei, 1'b1, ei});
      chk($sformatf("onehot_%0d", k), {6'b0, ($countones(gnt8) <= 1)}, 7'd1);
    end

    // ---------- fairness, MAX_HOLD=1, req=1111 ----------
    rst = 1'b1; req8 = 4'b0000; req1 = 4'b1111;
    step();
    chk("fair_rst", {gnt1, val1, idx1}, 7'b0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic [1:0] ei;
      step();
      ei = 2'(k % 4);
      chk($sformatf("fair_%0d", k), {gnt1, val1, idx1}, {4'b0001 << ei, 1'b1, ei});
    end

    // ---------- randomized traffic vs model, both instances ----------
    rst = 1'b1;
    step();
    model_step(0, 1'b1, req8);
    model_step(1, 1'b1, req1);
    rst = 1'b0;
    req8 = 4'($urandom); req1 = 4'($urandom);
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 79) == 0);
      // Sticky requests so that tenures regularly reach the hold limit.
      req8 = req8 ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      req1 = req1 ^ (4'($urandom) & 4'($urandom));
      step();
      model_step(0, rst, req8);
      model_step(1, rst, req1);
      chk($sformatf("rand8_%0d", k), {gnt8, val8, idx8}, model_out(0));
      chk($sformatf("rand1_%0d", k), {gnt1, val1, idx1}, model_out(1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
